gcbank_ctrl: RTL and testbench
==============================

GCBANK_CTRL -- requirements
Module: gcbank_ctrl

Interface
REQ-001 Parameter LOGFFTSIZE, default 10: log2 of gain-curve length (FFT bins per frame).
REQ-002 Parameter GCRVEWIDTH, default 8: gain-curve word width.
REQ-003 Parameter TOWIDTH, default 24: width of the load-timeout counter.
REQ-004 Parameter TIMEOUT, default 24'd5_000_000: clk cycles without loader address progress before a load is aborted.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 load_req  in  1  one-cycle pulse: start loading a new curve into the shadow bank.
REQ-008 frame_start  in  1  one-cycle pulse from the FFT engine, one cycle before bin 0 of a frame is read.
REQ-009 ld_run  out  1  level enable to the serial gain-curve loader; low restarts the loader at index 0.
REQ-010 ld_addr  in  LOGFFTSIZE  loader write index.
REQ-011 ld_din  in  GCRVEWIDTH  loader write data.
REQ-012 ld_we  in  1  loader write enable; held high while the loader is working.
REQ-013 rd_addr  in  LOGFFTSIZE  bin index requested by the gain multiplier.
REQ-014 ram_waddr  out  LOGFFTSIZE+1  = {shadow_bank, ld_addr}, combinational.
REQ-015 ram_din  out  GCRVEWIDTH  = ld_din, combinational.
REQ-016 ram_we  out  1  = ld_we AND state==LOAD, combinational.
REQ-017 ram_raddr  out  LOGFFTSIZE+1  = {active_bank, rd_addr}, combinational.
REQ-018 active_bank  out  1  bank currently read by the datapath; shadow_bank = ~active_bank.
REQ-019 busy  out  1  high in LOAD or PEND.
REQ-020 err_timeout  out  1  sticky; set on load abort, cleared by next accepted load_req.

Function
REQ-021 FSM states IDLE, LOAD, PEND; state, active_bank, err_timeout, timeout counter, last-address register are registers.
REQ-022 IDLE: load_req -> LOAD, clear err_timeout, clear timeout counter; ld_run low.
REQ-023 LOAD: ld_run high; ram_we follows ld_we into the shadow bank.
REQ-024 LOAD: timeout counter clears whenever ld_addr differs from its value the previous cycle, else increments.
REQ-025 LOAD: counter == TIMEOUT-1 -> IDLE, set err_timeout, active_bank unchanged.
REQ-026 LOAD: a cycle with ld_we high and ld_addr == 2^LOGFFTSIZE-1, followed by the first cycle with ld_we low -> PEND.
REQ-027 LOAD: load_req ignored.
REQ-028 PEND: ld_run low; frame_start -> active_bank toggles on that edge, state -> IDLE.
REQ-029 PEND: load_req without frame_start -> LOAD (pending curve discarded, shadow bank reloaded from index 0).
REQ-030 PEND: load_req and frame_start in the same cycle -> swap takes priority, next state IDLE, load_req dropped.
REQ-031 active_bank changes only per REQ-028; never mid-frame for any other cause.
REQ-032 Write and read addresses always target different banks; no read/write collision arbitration is required.

Reset
REQ-033 rst high: state IDLE, active_bank 0, err_timeout 0, timeout counter 0, ld_run 0, busy 0, ram_we 0; takes effect without a clock edge, mid-load included.

Structure
REQ-034 State encodings and the bank-address concatenation width belong in a shared peq package; parameters stay on the module.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Reset, load_req, loader writes 0..1023 with ld_we, then ld_we low -> PEND; frame_start -> active_bank 0->1, ram_raddr[10]=1.
REQ-037 ld_addr stalls at 37 with TIMEOUT=100 -> IDLE after 100 cycles, err_timeout=1, active_bank unchanged; next load_req clears err_timeout.
REQ-038 In PEND, load_req alone -> LOAD, ld_run low one cycle then high, active_bank unchanged.
REQ-039 In PEND, load_req and frame_start same cycle -> active_bank toggles, state IDLE, ld_run stays 0.
REQ-040 rst asserted at ld_addr=500 in LOAD -> all outputs at reset values immediately, ram_we=0.
REQ-041 During LOAD, ram_waddr[10]==~ram_raddr[10] on every cycle; ram_we=0 in IDLE and PEND even with ld_we=1.

Source files
------------

// File: rtl/gcbank_ctrl_pkg.sv
// Shared definitions for the double-buffered gain-curve bank controller:
// FSM state encoding and the width of a bank-qualified RAM address.
package gcbank_ctrl_pkg;

    // Controller states: waiting, filling the shadow bank, or waiting for a
    // frame boundary to swap the freshly loaded bank in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    // One bank-select bit sits above the bin index in every RAM address.
    localparam int unsigned BANK_SEL_W = 1;

    // Width of {bank, bin_index} for a curve of 2^log_fft_size bins.
    function automatic int unsigned bank_addr_w(input int unsigned log_fft_size);
        return log_fft_size + BANK_SEL_W;
    endfunction

endpackage

// File: rtl/gcbank_ctrl.sv
// Gain-curve bank controller. The datapath reads the active bank while a
// serial loader fills the shadow bank; the banks swap only at a frame
// boundary once a complete curve has been written. A stalled loader is
// aborted after TIMEOUT cycles without address progress.
module gcbank_ctrl
    import gcbank_ctrl_pkg::*;
#(
    parameter int unsigned         LOGFFTSIZE = 10,
    parameter int unsigned         GCRVEWIDTH = 8,
    parameter int unsigned         TOWIDTH    = 24,
    parameter logic [TOWIDTH-1:0]  TIMEOUT    = 24'd5_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load_req,
    input  logic                                   frame_start,
    output logic                                   ld_run,
    input  logic [LOGFFTSIZE-1:0]                  ld_addr,
    input  logic [GCRVEWIDTH-1:0]                  ld_din,
    input  logic                                   ld_we,
    input  logic [LOGFFTSIZE-1:0]                  rd_addr,
    output logic [bank_addr_w(LOGFFTSIZE)-1:0]     ram_waddr,
    output logic [GCRVEWIDTH-1:0]                  ram_din,
    output logic                                   ram_we,
    output logic [bank_addr_w(LOGFFTSIZE)-1:0]     ram_raddr,
    output logic                                   active_bank,
    output logic                                   busy,
    output logic                                   err_timeout
);

    localparam logic [LOGFFTSIZE-1:0] ADDR_LAST = '1;
    localparam logic [TOWIDTH-1:0]    TO_LAST   = TIMEOUT - 1'b1;

    state_e                  state_q, state_d;
    logic                    active_bank_q, active_bank_d;
    logic                    err_timeout_q, err_timeout_d;
    logic [TOWIDTH-1:0]      to_cnt_q, to_cnt_d;
    logic [LOGFFTSIZE-1:0]   last_addr_q;
    // Set once the final bin has been written; the next ld_we-low cycle
    // marks the end of the load.
    logic                    last_seen_q, last_seen_d;

    // Next-state and control decode for the load/swap FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        active_bank_d = active_bank_q;
        err_timeout_d = err_timeout_q;
        to_cnt_d      = to_cnt_q;
        last_seen_d   = last_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d       = ST_LOAD;
                    err_timeout_d = 1'b0;
                    to_cnt_d      = '0;
                    last_seen_d   = 1'b0;
                end
            end

            ST_LOAD: begin
                // Any address movement counts as loader progress.
                if (ld_addr != last_addr_q) begin
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end

                if (ld_we && (ld_addr == ADDR_LAST)) begin
                    last_seen_d = 1'b1;
                end

                // A finished curve wins over a coincident timeout.
                if (last_seen_q && !ld_we) begin
                    state_d = ST_PEND;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = ST_IDLE;
                    err_timeout_d = 1'b1;
                end
            end

            ST_PEND: begin
                // The swap takes priority; a simultaneous load_req is dropped.
                if (frame_start) begin
                    active_bank_d = ~active_bank_q;
                    state_d       = ST_IDLE;
                end else if (load_req) begin
                    state_d       = ST_LOAD;
                    err_timeout_d = 1'b0;
                    to_cnt_d      = '0;
                    last_seen_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset so an abort mid-load is immediate.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= ST_IDLE;
            active_bank_q <= 1'b0;
            err_timeout_q <= 1'b0;
            to_cnt_q      <= '0;
            last_addr_q   <= '0;
            last_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            err_timeout_q <= err_timeout_d;
            to_cnt_q      <= to_cnt_d;
            last_addr_q   <= ld_addr;
            last_seen_q   <= last_seen_d;
        end
    end

    // Bank-qualified RAM ports: writes always go to the shadow bank and
    // reads to the active bank, so the two can never collide.
    always_comb begin
        ram_waddr   = {~active_bank_q, ld_addr};
        ram_raddr   = {active_bank_q, rd_addr};
        ram_din     = ld_din;
        ram_we      = ld_we && (state_q == ST_LOAD);
        ld_run      = (state_q == ST_LOAD);
        busy        = (state_q != ST_IDLE);
        active_bank = active_bank_q;
        err_timeout = err_timeout_q;
    end

endmodule

// File: tb/tb_gcbank_ctrl.sv
// Self-checking bench for gcbank_ctrl: address-mapping vector table, a
// write scoreboard for loader traffic, and directed swap/timeout/reset
// sequences.
module tb_gcbank_ctrl;

    localparam int unsigned LOGFFTSIZE = 10;
    localparam int unsigned GCRVEWIDTH = 8;
    localparam int unsigned TOWIDTH    = 24;
    localparam int unsigned NBINS      = 1 << LOGFFTSIZE;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load_req;
    logic                  frame_start;
    logic                  ld_run;
    logic [LOGFFTSIZE-1:0] ld_addr;
    logic [GCRVEWIDTH-1:0] ld_din;
    logic                  ld_we;
    logic [LOGFFTSIZE-1:0] rd_addr;
    logic [LOGFFTSIZE:0]   ram_waddr;
    logic [GCRVEWIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [LOGFFTSIZE:0]   ram_raddr;
    logic                  active_bank;
    logic                  busy;
    logic                  err_timeout;

    gcbank_ctrl #(
        .LOGFFTSIZE (LOGFFTSIZE),
        .GCRVEWIDTH (GCRVEWIDTH),
        .TOWIDTH    (TOWIDTH),
        .TIMEOUT    (24'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .frame_start (frame_start),
        .ld_run      (ld_run),
        .ld_addr     (ld_addr),
        .ld_din      (ld_din),
        .ld_we       (ld_we),
        .rd_addr     (rd_addr),
        .ram_waddr   (ram_waddr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_raddr   (ram_raddr),
        .active_bank (active_bank),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOGFFTSIZE-1:0] ld_addr;
        logic [GCRVEWIDTH-1:0] ld_din;
        logic                  ld_we;
        logic [LOGFFTSIZE-1:0] rd_addr;
        logic [LOGFFTSIZE:0]   exp_waddr;
        logic [LOGFFTSIZE:0]   exp_raddr;
        logic                  exp_we_load;
    } vec_t;

    typedef struct {
        logic [LOGFFTSIZE:0]   waddr;
        logic [GCRVEWIDTH-1:0] din;
    } wr_t;

    vec_t tbl [6];
    wr_t  sb_q [$];
    int   checks   = 0;
    int   failures = 0;
    logic bank_m   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loader writes observed on the RAM port are matched in order against
    // the writes the bench issued while the controller should be loading.
    always @(negedge clk) begin
        if (!rst && ram_we) begin
            check("sb_write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                check("sb_waddr", 32'(ram_waddr), 32'(e.waddr));
                check("sb_din", 32'(ram_din), 32'(e.din));
            end
        end
        if (!rst && busy) begin
            check("bank_split", 32'(ram_waddr[LOGFFTSIZE] ^ ram_raddr[LOGFFTSIZE]), 32'd1);
        end
    end

    task automatic pulse_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic apply_table(input bit in_load);
        for (int i = 0; i < 6; i++) begin
            ld_addr = tbl[i].ld_addr;
            ld_din  = tbl[i].ld_din;
            ld_we   = tbl[i].ld_we;
            rd_addr = tbl[i].rd_addr;
            if (in_load && tbl[i].ld_we) sb_q.push_back('{tbl[i].exp_waddr, tbl[i].ld_din});
            #1;
            check($sformatf("tbl%0d_waddr", i), 32'(ram_waddr), 32'(tbl[i].exp_waddr));
            check($sformatf("tbl%0d_raddr", i), 32'(ram_raddr), 32'(tbl[i].exp_raddr));
            check($sformatf("tbl%0d_din", i), 32'(ram_din), 32'(tbl[i].ld_din));
            check($sformatf("tbl%0d_we", i), 32'(ram_we), in_load ? 32'(tbl[i].exp_we_load) : 32'd0);
            tick();
        end
        ld_we = 1'b0;
    endtask

    // Full curve write 0..NBINS-1 then ld_we low; leaves the DUT in PEND.
    task automatic full_load();
        for (int i = 0; i < NBINS; i++) begin
            ld_addr = LOGFFTSIZE'(i);
            ld_din  = GCRVEWIDTH'($urandom);
            rd_addr = LOGFFTSIZE'($urandom);
            ld_we   = 1'b1;
            sb_q.push_back('{{~bank_m, ld_addr}, ld_din});
            tick();
        end
        ld_we = 1'b0;
        tick();
        check("load_done_busy", 32'(busy), 32'd1);
        check("load_done_ld_run", 32'(ld_run), 32'd0);
        check("load_done_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic swap();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bank_m = ~bank_m;
        check("swap_bank", 32'(active_bank), 32'(bank_m));
        check("swap_raddr_msb", 32'(ram_raddr[LOGFFTSIZE]), 32'(bank_m));
        check("swap_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;

        tbl[0] = '{10'd0,    8'h11, 1'b1, 10'd0,    11'h400, 11'h000, 1'b1};
        tbl[1] = '{10'd1023, 8'hA5, 1'b0, 10'd1023, 11'h7FF, 11'h3FF, 1'b0};
        tbl[2] = '{10'd512,  8'h3C, 1'b1, 10'd511,  11'h600, 11'h1FF, 1'b1};
        tbl[3] = '{10'd255,  8'hFF, 1'b1, 10'd256,  11'h4FF, 11'h100, 1'b1};
        tbl[4] = '{10'd1022, 8'h00, 1'b1, 10'd1,    11'h7FE, 11'h001, 1'b1};
        tbl[5] = '{10'd37,   8'h5A, 1'b0, 10'd1000, 11'h425, 11'h3E8, 1'b0};

        rst = 1'b1; load_req = 1'b0; frame_start = 1'b0;
        ld_addr = '0; ld_din = '0; ld_we = 1'b1; rd_addr = '0;
        #12;
        check("rst_ld_run", 32'(ld_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bank", 32'(active_bank), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        tick();

        // Address mapping with no writes allowed, then inside a load.
        apply_table(1'b0);
        pulse_load_req();
        check("load_busy", 32'(busy), 32'd1);
        check("load_ld_run", 32'(ld_run), 32'd1);
        apply_table(1'b1);

        // Complete load, write attempts in PEND are blocked, then swap.
        full_load();
        ld_we = 1'b1; ld_addr = 10'd5;
        #1;
        check("pend_ram_we_blocked", 32'(ram_we), 32'd0);
        tick();
        ld_we = 1'b0;
        check("pend_holds_bank", 32'(active_bank), 32'd0);
        swap();

        // Loader stalls at address 37 until the load is aborted.
        pulse_load_req();
        for (int i = 0; i < 37; i++) begin
            ld_addr = LOGFFTSIZE'(i); ld_din = GCRVEWIDTH'(i); ld_we = 1'b1;
            sb_q.push_back('{{~bank_m, ld_addr}, ld_din});
            tick();
        end
        ld_addr = 10'd37; ld_din = 8'd37; ld_we = 1'b1;
        sb_q.push_back('{{~bank_m, ld_addr}, ld_din});
        cycles = 0;
        while (cycles < 300) begin
            tick();
            ld_we = 1'b0;
            cycles++;
            if (!busy) break;
        end
        check("timeout_in_window", 32'(cycles >= 100 && cycles <= 101), 32'd1);
        check("timeout_err", 32'(err_timeout), 32'd1);
        check("timeout_bank", 32'(active_bank), 32'(bank_m));
        check("timeout_ld_run", 32'(ld_run), 32'd0);
        check("timeout_sb_empty", 32'(sb_q.size()), 32'd0);
        ld_we = 1'b1;
        #1;
        check("idle_ram_we_blocked", 32'(ram_we), 32'd0);
        ld_we = 1'b0;
        tick();
        pulse_load_req();
        check("reload_err_cleared", 32'(err_timeout), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);

        // PEND + load_req alone restarts the load without a swap.
        full_load();
        pulse_load_req();
        check("pend_reload_ld_run", 32'(ld_run), 32'd1);
        check("pend_reload_busy", 32'(busy), 32'd1);
        check("pend_reload_bank", 32'(active_bank), 32'(bank_m));

        // PEND + load_req + frame_start together: swap wins, request dropped.
        full_load();
        load_req = 1'b1;
        frame_start = 1'b1;
        tick();
        load_req = 1'b0;
        frame_start = 1'b0;
        bank_m = ~bank_m;
        check("both_bank", 32'(active_bank), 32'(bank_m));
        check("both_busy", 32'(busy), 32'd0);
        check("both_ld_run", 32'(ld_run), 32'd0);
        tick();
        check("both_dropped_busy", 32'(busy), 32'd0);
        check("both_dropped_ld_run", 32'(ld_run), 32'd0);

        // Bring active bank to 1, then reset asynchronously mid-load.
        pulse_load_req();
        full_load();
        swap();
        pulse_load_req();
        for (int i = 0; i <= 500; i++) begin
            ld_addr = LOGFFTSIZE'(i); ld_din = GCRVEWIDTH'($urandom); ld_we = 1'b1;
            sb_q.push_back('{{~bank_m, ld_addr}, ld_din});
            if (i < 500) tick();
        end
        #1;
        check("pre_rst_ram_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_ram_we", 32'(ram_we), 32'd0);
        check("async_rst_ld_run", 32'(ld_run), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_bank", 32'(active_bank), 32'd0);
        check("async_rst_err", 32'(err_timeout), 32'd0);
        check("async_rst_raddr_msb", 32'(ram_raddr[LOGFFTSIZE]), 32'd0);
        sb_q.delete();
        ld_we = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
